// File: rtl/matrix_fmt_pkg.sv
// ---------------------------------------------------------------------------
// matrix_fmt_pkg
//   Shared types and constants for the matrix text formatter:
//   - fmt_state_t : emission FSM states
//   - ASCII_*     : bytes used in the printed text
//   - BCD_DIGITS  : decimal digits needed for a 32-bit word
//   - entry_t     : one captured input event {end, end_row, en, data}
//   - count_digits: significant digit count of a BCD vector (0 -> 1)
// ---------------------------------------------------------------------------
package matrix_fmt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_CONV,
      ST_PAD,
      ST_DIGITS,
      ST_TERM
   } fmt_state_t;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SEMI  = 8'h3B;
   localparam logic [7:0] ASCII_NL    = 8'h0A;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;

   localparam int DATA_W     = 32;
   localparam int BCD_DIGITS = 10;
   localparam int BCD_W      = 4 * BCD_DIGITS;

   typedef struct packed {
      logic              is_end;
      logic              end_row;
      logic              en;
      logic [DATA_W-1:0] data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   // Position of the most significant non-zero digit, plus one.
   // A value of zero still prints one digit.
   function automatic logic [3:0] count_digits(input logic [BCD_W-1:0] bcd);
      logic [3:0] n;
      n = 4'd1;
      for (int i = 1; i < BCD_DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0) n = 4'(i + 1);
      end
      return n;
   endfunction

endpackage

// File: rtl/matrix_text_formatter_if.sv
// ---------------------------------------------------------------------------
// matrix_text_formatter_if
//   Bundles the matrix event stream (in_*), the byte stream toward the UART
//   (out_byte / out_byte_valid / out_byte_ready) and the status flags.
//   slave  : the formatter side
//   master : the producer / byte sink side
// ---------------------------------------------------------------------------
interface matrix_text_formatter_if;
   logic [31:0] in_matrix;
   logic        in_matrix_en;
   logic        in_end_row;
   logic        in_end;
   logic [7:0]  out_byte;
   logic        out_byte_valid;
   logic        out_byte_ready;
   logic        busy;
   logic        overflow;

   modport master (
      output in_matrix, in_matrix_en, in_end_row, in_end, out_byte_ready,
      input  out_byte, out_byte_valid, busy, overflow
   );

   modport slave (
      input  in_matrix, in_matrix_en, in_end_row, in_end, out_byte_ready,
      output out_byte, out_byte_valid, busy, overflow
   );
endinterface

// File: rtl/matrix_text_formatter_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential double-dabble converter: one shift/adjust step per cycle,
//   32 steps per conversion.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load bin and begin a conversion (one-cycle pulse)
//   bin        : 32-bit unsigned input
//   bcd        : 10 BCD digits, digit 0 in bits [3:0]; stable until next start
//   done       : high from the end of the last step until the next start
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import matrix_fmt_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] bin,
   output logic [BCD_W-1:0]  bcd,
   output logic              done
);

   localparam int ITER_W = $clog2(DATA_W);
   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DATA_W - 1);

   logic [DATA_W-1:0] shift_q;
   logic [BCD_W-1:0]  bcd_q;
   logic [BCD_W-1:0]  bcd_adj;
   logic [ITER_W-1:0] iter_q;
   logic              running_q;
   logic              done_q;

   // Add 3 to every digit >= 5 before the shift so it carries correctly.
   always_comb begin
      // NOTE: whole vector gets a default first so no path leaves it unassigned (no latch).
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q   <= '0;
         bcd_q     <= '0;
         iter_q    <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else if (start) begin
         shift_q   <= bin;
         bcd_q     <= '0;
         iter_q    <= '0;
         running_q <= 1'b1;
         done_q    <= 1'b0;
      end else if (running_q) begin
         bcd_q   <= (bcd_adj << 1) | BCD_W'(shift_q[DATA_W-1]);
         shift_q <= shift_q << 1;
         iter_q  <= iter_q + ITER_W'(1);
         if (iter_q == LAST_ITER) begin
            running_q <= 1'b0;
            done_q    <= 1'b1;
         end
      end
   end

   assign bcd  = bcd_q;
   assign done = done_q;

endmodule

// File: rtl/matrix_text_formatter.sv
// ---------------------------------------------------------------------------
// matrix_text_formatter
//   Turns the matrix output event stream into printable ASCII: each word
//   becomes a right-justified decimal field of at least FIELD_WIDTH chars,
//   end_row appends " ; \n", end appends "\n". Bytes leave on a
//   valid/ready stream.
//
//   Parameters : FIFO_DEPTH (power of 2, >= 2), FIELD_WIDTH
//   Ports      : clk, reset (async, active high)
//                bus.in_matrix/in_matrix_en/in_end_row/in_end : event input
//                bus.out_byte/out_byte_valid/out_byte_ready   : byte output
//                bus.busy     : FIFO non-empty or FSM not idle
//                bus.overflow : sticky, an event was dropped on a full FIFO
//   Build option: MATRIX_FMT_SIGNED_EN - print data as two's complement,
//                 '-' placed just before the first digit, inside the field.
// ---------------------------------------------------------------------------
module matrix_text_formatter
   import matrix_fmt_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int FIELD_WIDTH = 8
) (
   input logic                    clk,
   input logic                    reset,
   matrix_text_formatter_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int PAD_W = $clog2(FIELD_WIDTH + 1);

   // ---------------- input event FIFO ----------------
   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr, rd_ptr;
   logic               fifo_empty, fifo_full;
   logic               push_req, push_ok, pop;
   logic               overflow_q;
   entry_t             push_entry, head;

   fmt_state_t state, state_next;

   assign push_entry = '{is_end: bus.in_end, end_row: bus.in_end_row,
                         en: bus.in_matrix_en, data: bus.in_matrix};
   assign push_req   = bus.in_matrix_en | bus.in_end_row | bus.in_end;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop        = (state == ST_POP);
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok    = push_req && (!fifo_full || pop);
   assign head       = entry_t'(fifo_mem[rd_ptr[PTR_W-1:0]]);

   // NOTE: storage array has no reset; pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr[PTR_W-1:0]] <= push_entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         if (push_req && !push_ok) overflow_q <= 1'b1;
      end
   end

   // ---------------- converter ----------------
   logic [DATA_W-1:0] conv_in;
   logic [BCD_W-1:0]  conv_bcd;
   logic              conv_start, conv_done;

`ifdef MATRIX_FMT_SIGNED_EN
   logic cur_neg, sign_pending;
   assign conv_in = head.data[DATA_W-1] ? (DATA_W'(0) - head.data) : head.data;
`else
   assign conv_in = head.data;
`endif

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .bin   (conv_in),
      .bcd   (conv_bcd),
      .done  (conv_done)
   );

   // ---------------- field geometry ----------------
   logic [3:0] ndigits;
   int         field_len;
   int         pad_n;

   always_comb begin
      ndigits   = count_digits(conv_bcd);
      field_len = int'(ndigits);
`ifdef MATRIX_FMT_SIGNED_EN
      field_len = field_len + int'(cur_neg);
`endif
      pad_n = (FIELD_WIDTH > field_len) ? (FIELD_WIDTH - field_len) : 0;
   end

   // ---------------- emission FSM ----------------
   logic [PAD_W-1:0] pad_cnt;
   logic [3:0]       dig_idx;
   logic [2:0]       term_idx;   // 0..3 -> " ; \n", 4 -> "\n"
   logic             cur_end_row, cur_end;
   logic [3:0]       cur_digit;
   logic [7:0]       byte_c, term_byte;
   logic             valid_c, last_digit, term_last, xfer;

   assign cur_digit = conv_bcd[{dig_idx, 2'b00} +: 4];
   assign term_last = (term_idx == 3'd4) || (term_idx == 3'd3 && !cur_end);
   assign xfer      = valid_c & bus.out_byte_ready;

   always_comb begin
      case (term_idx)
         3'd1:    term_byte = ASCII_SEMI;
         3'd0,
         3'd2:    term_byte = ASCII_SPACE;
         default: term_byte = ASCII_NL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      byte_c     = 8'h00;
      valid_c    = 1'b0;
      conv_start = 1'b0;
      last_digit = 1'b0;
      case (state)
         ST_IDLE: if (!fifo_empty) state_next = ST_POP;
         ST_POP: begin
            conv_start = head.en;
            state_next = head.en ? ST_CONV : ST_TERM;
         end
         // Skip PAD entirely when the field is already full width.
         ST_CONV: if (conv_done) state_next = (pad_n != 0) ? ST_PAD : ST_DIGITS;
         ST_PAD: begin
            valid_c = 1'b1;
            byte_c  = ASCII_SPACE;
            if (bus.out_byte_ready && pad_cnt == PAD_W'(1)) state_next = ST_DIGITS;
         end
         ST_DIGITS: begin
            valid_c    = 1'b1;
            byte_c     = ASCII_ZERO + {4'h0, cur_digit};
            last_digit = (dig_idx == 4'd0);
`ifdef MATRIX_FMT_SIGNED_EN
            if (sign_pending) begin
               byte_c     = ASCII_MINUS;
               last_digit = 1'b0;
            end
`endif
            if (bus.out_byte_ready && last_digit)
               state_next = (cur_end_row || cur_end) ? ST_TERM : ST_IDLE;
         end
         ST_TERM: begin
            valid_c = 1'b1;
            byte_c  = term_byte;
            if (bus.out_byte_ready && term_last) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pad_cnt     <= '0;
         dig_idx     <= '0;
         term_idx    <= '0;
         cur_end_row <= 1'b0;
         cur_end     <= 1'b0;
`ifdef MATRIX_FMT_SIGNED_EN
         cur_neg      <= 1'b0;
         sign_pending <= 1'b0;
`endif
      end else begin
         case (state)
            ST_POP: begin
               cur_end_row <= head.end_row;
               cur_end     <= head.is_end;
               term_idx    <= head.end_row ? 3'd0 : 3'd4;
`ifdef MATRIX_FMT_SIGNED_EN
               cur_neg      <= head.en & head.data[DATA_W-1];
               sign_pending <= head.en & head.data[DATA_W-1];
`endif
            end
            ST_CONV: if (conv_done) begin
               pad_cnt <= PAD_W'(pad_n);
               dig_idx <= ndigits - 4'd1;
            end
            ST_PAD: if (xfer) pad_cnt <= pad_cnt - PAD_W'(1);
            ST_DIGITS: if (xfer) begin
`ifdef MATRIX_FMT_SIGNED_EN
               if (sign_pending)           sign_pending <= 1'b0;
               else if (dig_idx != 4'd0)   dig_idx <= dig_idx - 4'd1;
`else
               if (dig_idx != 4'd0) dig_idx <= dig_idx - 4'd1;
`endif
            end
            ST_TERM: if (xfer) term_idx <= (term_idx == 3'd3) ? 3'd4 : term_idx + 3'd1;
            default: ;
         endcase
      end
   end

   assign bus.out_byte       = byte_c;
   assign bus.out_byte_valid = valid_c;
   assign bus.busy           = !fifo_empty || (state != ST_IDLE);
   assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_matrix_text_formatter.sv
// ---------------------------------------------------------------------------
// tb_matrix_text_formatter
//   Directed bench for matrix_text_formatter (default unsigned build,
//   FIFO_DEPTH=8, FIELD_WIDTH=8). Inputs change 1ns after the rising edge,
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_matrix_text_formatter;

   logic clk = 1'b0;
   logic reset;

   matrix_text_formatter_if bus_if ();

   matrix_text_formatter #(
      .FIFO_DEPTH  (8),
      .FIELD_WIDTH (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int first_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   task automatic push(input logic [31:0] d, input logic en, input logic er, input logic e);
      bus_if.in_matrix    = d;
      bus_if.in_matrix_en = en;
      bus_if.in_end_row   = er;
      bus_if.in_end       = e;
      @(posedge clk);
      #1;
      bus_if.in_matrix    = 32'd0;
      bus_if.in_matrix_en = 1'b0;
      bus_if.in_end_row   = 1'b0;
      bus_if.in_end       = 1'b0;
   endtask

   // Receive text.len() bytes and compare each in order. toggle=0 keeps
   // ready high; otherwise ready alternates every 'toggle' cycles and a
   // stalled byte must stay valid and unchanged. first_cyc records the cycle
   // (counted from the call) on which valid was first seen.
   task automatic expect_text(input string tag, input string text, input int toggle, input int budget);
      int         cyc = 0;
      int         idx = 0;
      logic       held = 1'b0;
      logic [7:0] held_byte = 8'h00;
      first_cyc = -1;
      while (idx < text.len() && cyc < budget) begin
         bus_if.out_byte_ready = (toggle == 0) ? 1'b1 : (((cyc / toggle) % 2) == 0);
         @(negedge clk);
         if (held)
            check($sformatf("%s_hold", tag),
                  {23'd0, bus_if.out_byte_valid, bus_if.out_byte}, {23'd0, 1'b1, held_byte});
         if (bus_if.out_byte_valid && first_cyc < 0) first_cyc = cyc;
         held      = bus_if.out_byte_valid && !bus_if.out_byte_ready;
         held_byte = bus_if.out_byte;
         if (bus_if.out_byte_valid && bus_if.out_byte_ready) begin
            check($sformatf("%s[%0d]", tag, idx), {24'd0, bus_if.out_byte}, {24'd0, text[idx]});
            idx++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check($sformatf("%s_len", tag), 32'(idx), 32'(text.len()));
   endtask

   initial begin
      reset                 = 1'b1;
      bus_if.out_byte_ready = 1'b0;
      bus_if.in_matrix      = 32'd0;
      bus_if.in_matrix_en   = 1'b0;
      bus_if.in_end_row     = 1'b0;
      bus_if.in_end         = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_byte",     {24'd0, bus_if.out_byte}, 32'h00);
      check("rst_valid",    {31'd0, bus_if.out_byte_valid}, 32'd0);
      check("rst_busy",     {31'd0, bus_if.busy}, 32'd0);
      check("rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // 42 -> six spaces then "42"; first byte 35 cycles after the push
      push(32'd42, 1'b1, 1'b0, 1'b0);
      expect_text("w42", "      42", 0, 200);
      check("w42_lat", 32'(first_cyc), 32'd35);
      @(negedge clk);
      check("w42_busy_low", {31'd0, bus_if.busy}, 32'd0);
      @(posedge clk);
      #1;

      // 0 with end_row in the same event
      push(32'd0, 1'b1, 1'b1, 1'b0);
      expect_text("w0_row", "       0 ; \n", 0, 200);
      check("w0_lat", 32'(first_cyc), 32'd35);

      // Ten digits: no padding, still 35 cycles to the first byte
      push(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      expect_text("wmax", "4294967295", 0, 200);
      check("wmax_lat", 32'(first_cyc), 32'd35);

      // Matrix terminator only: first byte 2 cycles after the push
      push(32'd0, 1'b0, 1'b0, 1'b1);
      expect_text("end_only", "\n", 0, 50);
      check("end_only_lat", 32'(first_cyc), 32'd2);

      // Ready toggling every 3 cycles
      push(32'd7, 1'b1, 1'b0, 1'b0);
      expect_text("w7_stall", "       7", 3, 300);

      // Exactly full FIFO: pop and push in the same cycle must not drop
      bus_if.out_byte_ready = 1'b0;
      repeat (9) push(32'd0, 1'b0, 1'b0, 1'b1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("full_valid", {31'd0, bus_if.out_byte_valid}, 32'd1);
      check("full_byte",  {24'd0, bus_if.out_byte}, 32'h0A);
      check("full_no_ovf", {31'd0, bus_if.overflow}, 32'd0);
      @(posedge clk);
      #1;
      bus_if.out_byte_ready = 1'b1;      // first "\n" leaves at the next edge
      @(posedge clk);
      #1;
      bus_if.out_byte_ready = 1'b0;      // IDLE this cycle, POP the next
      @(posedge clk);
      #1;
      push(32'd0, 1'b0, 1'b1, 1'b0);     // lands on the POP edge while full
      @(negedge clk);
      check("full_pushpop_ovf", {31'd0, bus_if.overflow}, 32'd0);
      @(posedge clk);
      #1;
      expect_text("full_drain", "\n\n\n\n\n\n\n\n ; \n", 0, 300);

      // Ten pushes with ready low: entry 1 popped, 2..9 stored, 10 dropped
      bus_if.out_byte_ready = 1'b0;
      for (int i = 1; i <= 10; i++) push(32'(i), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("ovf_set", {31'd0, bus_if.overflow}, 32'd1);
      @(posedge clk);
      #1;
      expect_text("ovf_drain",
                  "       1       2       3       4       5       6       7       8       9",
                  0, 1000);
      @(negedge clk);
      check("ovf_drain_busy", {31'd0, bus_if.busy}, 32'd0);
      check("ovf_sticky",     {31'd0, bus_if.overflow}, 32'd1);
      @(posedge clk);
      #1;

      // Reset in the middle of the digits of 12345
      push(32'd12345, 1'b1, 1'b0, 1'b0);
      expect_text("mid", "   12", 0, 200);
      bus_if.out_byte_ready = 1'b0;
      @(negedge clk);
      check("mid_in_digits", {24'd0, bus_if.out_byte}, 32'h33);
      reset = 1'b1;
      #1;
      check("mid_rst_valid",    {31'd0, bus_if.out_byte_valid}, 32'd0);
      check("mid_rst_busy",     {31'd0, bus_if.busy}, 32'd0);
      check("mid_rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      push(32'd9, 1'b1, 1'b0, 1'b0);
      expect_text("after_rst", "       9", 0, 200);
      check("after_rst_lat", 32'(first_cyc), 32'd35);
      @(negedge clk);
      check("after_rst_idle", {31'd0, bus_if.busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
